// File: rtl/div_32_iter.sv
// Iterative signed divider: restoring algorithm, one quotient bit per cycle.
// Returns quotient only (truncated toward zero); flags divide-by-zero in a single cycle.
module div_32_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_div,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state_q,  state_d;
  logic [WIDTH-1:0] quo_q,    quo_d;
  logic [WIDTH-1:0] b_q,      b_d;
  logic [WIDTH-1:0] rem_q,    rem_d;
  logic [CW-1:0]    count_q,  count_d;
  logic             sign_q,   sign_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             exc_q,    exc_d;
  logic             rdy_q,    rdy_d;
  logic             busy_q,   busy_d;

  logic [WIDTH-1:0] a_abs_c;
  logic [WIDTH-1:0] b_abs_c;
  logic [WIDTH:0]   rem_sh_c;
  logic [WIDTH:0]   trial_c;

  // Magnitudes fit unsigned WIDTH bits, including -2^(WIDTH-1)
  always_comb begin
    a_abs_c = data_operandA[WIDTH-1] ? (~data_operandA + WIDTH'(1)) : data_operandA;
    b_abs_c = data_operandB[WIDTH-1] ? (~data_operandB + WIDTH'(1)) : data_operandB;
    rem_sh_c = {rem_q, quo_q[WIDTH-1]};
    trial_c  = rem_sh_c - {1'b0, b_q};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      quo_q    <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      count_q  <= '0;
      sign_q   <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      quo_q    <= quo_d;
      b_q      <= b_d;
      rem_q    <= rem_d;
      count_q  <= count_d;
      sign_q   <= sign_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    quo_d    = quo_q;
    b_d      = b_q;
    rem_d    = rem_q;
    count_d  = count_q;
    sign_d   = sign_q;
    result_d = result_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;
    busy_d   = busy_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (ctrl_div) begin
          quo_d   = a_abs_c;
          b_d     = b_abs_c;
          sign_d  = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
          rem_d   = '0;
          count_d = '0;
          if (data_operandB == '0) begin
            state_d  = S_DONE;
            result_d = '0;
            exc_d    = 1'b1;
            rdy_d    = 1'b1;
          end else begin
            state_d = S_RUN;
            busy_d  = 1'b1;
          end
        end
      end
      S_RUN: begin
        // Restore when the trial subtraction goes negative
        rem_d   = trial_c[WIDTH] ? rem_sh_c[WIDTH-1:0] : trial_c[WIDTH-1:0];
        quo_d   = {quo_q[WIDTH-2:0], ~trial_c[WIDTH]};
        count_d = count_q + CW'(1);
        if (count_q == CW'(WIDTH - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        result_d = sign_q ? (~quo_q + WIDTH'(1)) : quo_q;
        exc_d    = 1'b0;
        rdy_d    = 1'b1;
        busy_d   = 1'b0;
        state_d  = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_div_32_iter.sv
// Directed bench for div_32_iter: expected results queued at issue, checked on each rdy pulse.
module tb_div_32_iter;

  logic        clock;
  logic        reset_n;
  logic        ctrl_div;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  typedef struct packed {
    logic [31:0] res;
    logic        exc;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  div_32_iter dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_div       (ctrl_div),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every rdy pulse must match the oldest queued expectation
  always @(negedge clock) begin
    if (reset_n && data_resultRDY === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_rdy", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", data_result, e.res);
        chk("exception", {31'd0, data_exception}, {31'd0, e.exc});
      end
    end
  end

  // Issue one op and measure edges after capture until rdy is seen; optionally
  // inject a 9/9 start request on edge inj_edge while the op is in flight.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic exp_exc,
                        input int exp_lat, input int exp_busy, input int inj_edge,
                        input string tag);
    int lat;
    int nbusy;
    exp_t e;
    @(negedge clock);
    ctrl_div = 1'b1;
    data_operandA = a;
    data_operandB = b;
    e.res = exp_res;
    e.exc = exp_exc;
    sb.push_back(e);
    @(posedge clock);
    #1;
    ctrl_div = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
    lat = 0;
    nbusy = 0;
    while (data_resultRDY !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) nbusy++;
      if (inj_edge != 0 && lat + 1 == inj_edge) begin
        ctrl_div = 1'b1;
        data_operandA = 32'd9;
        data_operandB = 32'd9;
      end else begin
        ctrl_div = 1'b0;
      end
      @(posedge clock);
      #1;
      lat++;
    end
    ctrl_div = 1'b0;
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_busy_cycles"}, 32'(nbusy), 32'(exp_busy));
  endtask

  initial begin
    reset_n = 1'b0;
    ctrl_div = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (2) @(negedge clock);
    chk("reset_result", data_result, 32'd0);
    chk("reset_exc", {31'd0, data_exception}, 32'd0);
    chk("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    reset_n = 1'b1;

    run_op(32'd100, 32'd7, 32'd14, 1'b0, 33, 33, 0, "p100_p7");
    run_op(-32'sd100, 32'd7, 32'hFFFF_FFF2, 1'b0, 33, 33, 0, "m100_p7");
    run_op(32'd100, -32'sd7, 32'hFFFF_FFF2, 1'b0, 33, 33, 0, "p100_m7");
    run_op(-32'sd100, -32'sd7, 32'd14, 1'b0, 33, 33, 0, "m100_m7");
    run_op(32'd7, 32'd100, 32'd0, 1'b0, 33, 33, 0, "p7_p100");
    run_op(-32'sd3, 32'd7, 32'd0, 1'b0, 33, 33, 0, "m3_p7");
    run_op(32'd0, 32'd5, 32'd0, 1'b0, 33, 33, 0, "zero_p5");

    // Divide by zero: rdy visible in the cycle right after capture, busy never set
    run_op(32'd5, 32'd0, 32'd0, 1'b1, 0, 0, 0, "div0");
    @(posedge clock);
    #1;
    chk("div0_exc_held", {31'd0, data_exception}, 32'd1);
    chk("div0_rdy_drop", {31'd0, data_resultRDY}, 32'd0);
    run_op(32'd9, 32'd3, 32'd3, 1'b0, 33, 33, 0, "p9_p3");

    run_op(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 33, 33, 0, "min_m1");
    run_op(32'h7FFF_FFFF, 32'd1, 32'h7FFF_FFFF, 1'b0, 33, 33, 0, "max_p1");
    run_op(32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0, 33, 33, 0, "min_p1");

    // Async reset mid-operation discards the op without a pulse
    @(negedge clock);
    ctrl_div = 1'b1;
    data_operandA = 32'd1000;
    data_operandB = 32'd10;
    @(posedge clock);
    #1;
    ctrl_div = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_result", data_result, 32'd0);
    chk("rst_mid_exc", {31'd0, data_exception}, 32'd0);
    chk("rst_mid_rdy", {31'd0, data_resultRDY}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    #1;
    reset_n = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_no_pulse", {31'd0, data_resultRDY}, 32'd0);
    run_op(32'd1000, 32'd10, 32'd100, 1'b0, 33, 33, 0, "p1000_p10");

    // Start request while busy is ignored; then back-to-back start from DONE
    run_op(32'd50, 32'd5, 32'd10, 1'b0, 33, 33, 5, "p50_p5_inj");
    run_op(32'd8, 32'd2, 32'd4, 1'b0, 33, 33, 0, "b2b_p8_p2");
    run_op(32'hFFFF_FFFF, 32'd0, 32'd0, 1'b1, 0, 0, 0, "b2b_div0");
    run_op(32'd21, -32'sd4, 32'hFFFF_FFFB, 1'b0, 33, 33, 0, "p21_m4");

    repeat (3) @(negedge clock);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
